// File: rtl/cpu_ctrl_if.sv
// Handshake and strobe bundle between the CPU control sequencer and its datapath/memories.
interface cpu_ctrl_if #(
    parameter int unsigned OP_W  = 3,
    parameter int unsigned RET_W = 16
);
    logic [OP_W-1:0]  opcode;
    logic             ins_ready;
    logic             da_ready;
    logic             is_zero;
    logic             resume;

    logic             pc_en;
    logic             pc_load;
    logic             mem_ins_en;
    logic             mem_da_en;
    logic             mem_da_we;
    logic             acc_load;
    logic             acc_ctrl;
    logic             halt;
    logic             illegal_op;
    logic             bus_err;
    logic [4:0]       state;
    logic [RET_W-1:0] retired;

    modport slave (
        input  opcode, ins_ready, da_ready, is_zero, resume,
        output pc_en, pc_load, mem_ins_en, mem_da_en, mem_da_we,
               acc_load, acc_ctrl, halt, illegal_op, bus_err, state, retired
    );

    modport master (
        output opcode, ins_ready, da_ready, is_zero, resume,
        input  pc_en, pc_load, mem_ins_en, mem_da_en, mem_da_we,
               acc_load, acc_ctrl, halt, illegal_op, bus_err, state, retired
    );
endinterface

// File: rtl/cpu_ctrl_seq.sv
// Multi-cycle CPU control sequencer: FETCH/DECODE/EXEC/WB/HALTED with memory-wait
// timeouts, sticky error flags and a retired-instruction counter.
module cpu_ctrl_seq #(
    parameter int unsigned OP_W     = 3,
    parameter int unsigned WAIT_MAX = 15,
    parameter int unsigned RET_W    = 16
) (
    input  logic       clk,
    input  logic       rst,
    cpu_ctrl_if.slave  bus
);
    localparam int unsigned CNT_W = 8;

    typedef enum logic [4:0] {
        S_FETCH  = 5'b00001,
        S_DECODE = 5'b00010,
        S_EXEC   = 5'b00100,
        S_WB     = 5'b01000,
        S_HALTED = 5'b10000
    } state_t;

    typedef enum logic [2:0] {
        OP_HLT = 3'd0,
        OP_SKZ = 3'd1,
        OP_ADD = 3'd2,
        OP_AND = 3'd3,
        OP_XOR = 3'd4,
        OP_LDA = 3'd5,
        OP_STO = 3'd6,
        OP_JMP = 3'd7
    } op_t;

    state_t           state_q, state_d;
    logic [OP_W-1:0]  ir_q;
    logic [CNT_W-1:0] wait_q, wait_d;
    logic [RET_W-1:0] retired_q;
    logic             illegal_q, bus_err_q;
    logic             set_illegal, set_bus_err;
    logic             ir_illegal;
    logic             is_mem_op;
    logic             wait_expired;
    op_t              op;

    assign op           = op_t'(ir_q[2:0]);
    assign is_mem_op    = op inside {OP_ADD, OP_AND, OP_XOR, OP_LDA, OP_STO};
    assign wait_expired = (wait_q == CNT_W'(WAIT_MAX - 1));

    // Opcode values above 7 only exist when the opcode is wider than 3 bits.
    if (OP_W > 3) begin : g_wide_op
        assign ir_illegal = |ir_q[OP_W-1:3];
    end else begin : g_narrow_op
        assign ir_illegal = 1'b0;
    end

    // State register, IR capture, wait counter, sticky flags and retire counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            ir_q      <= '0;
            wait_q    <= '0;
            retired_q <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (state_q == S_FETCH && state_d == S_DECODE) begin
                ir_q <= bus.opcode;
            end
            if (state_q == S_WB) begin
                retired_q <= retired_q + RET_W'(1);
            end
            if (set_illegal) begin
                illegal_q <= 1'b1;
            end
            if (set_bus_err) begin
                bus_err_q <= 1'b1;
            end
        end
    end

    // Next-state and Moore output decode.
    always_comb begin
        state_d        = state_q;
        wait_d         = '0;
        set_illegal    = 1'b0;
        set_bus_err    = 1'b0;
        bus.pc_en      = 1'b0;
        bus.pc_load    = 1'b0;
        bus.mem_ins_en = 1'b0;
        bus.mem_da_en  = 1'b0;
        bus.mem_da_we  = 1'b0;
        bus.acc_load   = 1'b0;
        bus.acc_ctrl   = 1'b0;
        bus.halt       = 1'b0;

        case (state_q)
            S_FETCH: begin
                bus.mem_ins_en = 1'b1;
                if (bus.ins_ready) begin
                    state_d = S_DECODE;
                end else if (wait_expired) begin
                    state_d     = S_HALTED;
                    set_bus_err = 1'b1;
                end
            end
            S_DECODE: begin
                bus.pc_en = 1'b1;
                if (ir_illegal) begin
                    state_d     = S_HALTED;
                    set_illegal = 1'b1;
                end else if (op == OP_HLT) begin
                    state_d = S_HALTED;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_mem_op) begin
                    bus.mem_da_en = 1'b1;
                    bus.mem_da_we = (op == OP_STO);
                    if (bus.da_ready) begin
                        state_d = S_WB;
                    end else if (wait_expired) begin
                        state_d     = S_HALTED;
                        set_bus_err = 1'b1;
                    end
                end else begin
                    bus.pc_load = (op == OP_JMP);
                    bus.pc_en   = (op == OP_SKZ) && bus.is_zero;
                    state_d     = S_WB;
                end
            end
            S_WB: begin
                bus.acc_load = op inside {OP_ADD, OP_AND, OP_XOR, OP_LDA};
                bus.acc_ctrl = (op == OP_LDA);
                state_d      = S_FETCH;
            end
            S_HALTED: begin
                bus.halt = 1'b1;
                if (bus.resume && !illegal_q && !bus_err_q) begin
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Count only while parked in a waiting state; any transition restarts it.
        if (state_d == state_q && (state_q == S_FETCH || state_q == S_EXEC)) begin
            wait_d = wait_q + CNT_W'(1);
        end

        // Strobes are forced off for as long as reset is held.
        if (rst) begin
            bus.pc_en      = 1'b0;
            bus.pc_load    = 1'b0;
            bus.mem_ins_en = 1'b0;
            bus.mem_da_en  = 1'b0;
            bus.mem_da_we  = 1'b0;
            bus.acc_load   = 1'b0;
            bus.acc_ctrl   = 1'b0;
        end
    end

    assign bus.state      = state_q;
    assign bus.retired    = retired_q;
    assign bus.illegal_op = illegal_q;
    assign bus.bus_err    = bus_err_q;
endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// Cycle-accurate bench for cpu_ctrl_seq: per-cycle stimulus rows carry the expected
// state/strobes/flags/retired, queued on drive and compared when sampled.
module tb_cpu_ctrl_seq;
    localparam int unsigned OP_W     = 4;
    localparam int unsigned WAIT_MAX = 4;
    localparam int unsigned RET_W    = 16;

    localparam logic [4:0] SF = 5'b00001;
    localparam logic [4:0] SD = 5'b00010;
    localparam logic [4:0] SE = 5'b00100;
    localparam logic [4:0] SW = 5'b01000;
    localparam logic [4:0] SH = 5'b10000;

    // Flag vector order: pc_en pc_load mem_ins_en mem_da_en mem_da_we acc_load acc_ctrl halt illegal_op bus_err
    localparam logic [9:0] NO = 10'b0000000000;
    localparam logic [9:0] PE = 10'b1000000000;
    localparam logic [9:0] PL = 10'b0100000000;
    localparam logic [9:0] MI = 10'b0010000000;
    localparam logic [9:0] MD = 10'b0001000000;
    localparam logic [9:0] MW = 10'b0000100000;
    localparam logic [9:0] AL = 10'b0000010000;
    localparam logic [9:0] AC = 10'b0000001000;
    localparam logic [9:0] HL = 10'b0000000100;
    localparam logic [9:0] IL = 10'b0000000010;
    localparam logic [9:0] BE = 10'b0000000001;

    typedef struct packed {
        logic        rst;
        logic        ins;
        logic        da;
        logic        zero;
        logic        res;
        logic [3:0]  opc;
        logic [4:0]  st;
        logic [9:0]  f;
        logic [15:0] ret;
    } row_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    row_t        rows[$];
    logic [30:0] sb[$];

    cpu_ctrl_if #(.OP_W(OP_W), .RET_W(RET_W)) bus ();

    cpu_ctrl_seq #(.OP_W(OP_W), .WAIT_MAX(WAIT_MAX), .RET_W(RET_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic add(input int r, input int i, input int d, input int z, input int s,
                       input int o, input logic [4:0] st, input logic [9:0] f, input int ret);
        rows.push_back({1'(r), 1'(i), 1'(d), 1'(z), 1'(s), 4'(o), st, f, 16'(ret)});
    endtask

    // Apply one cycle of inputs away from the active edge and queue its expectation.
    task automatic drive_row(input row_t r);
        @(negedge clk);
        rst           = r.rst;
        bus.ins_ready = r.ins;
        bus.da_ready  = r.da;
        bus.is_zero   = r.zero;
        bus.resume    = r.res;
        bus.opcode    = r.opc;
        sb.push_back({r.st, r.f, r.ret});
        #1;
    endtask

    function automatic logic [30:0] sample();
        return {bus.state, bus.pc_en, bus.pc_load, bus.mem_ins_en, bus.mem_da_en, bus.mem_da_we,
                bus.acc_load, bus.acc_ctrl, bus.halt, bus.illegal_op, bus.bus_err, bus.retired};
    endfunction

    task automatic test_reset();
        logic [30:0] got, exp_v;
        add(1,0,0,0,0,0, SF, NO, 0);
        add(1,1,1,1,1,5, SF, NO, 0);
        foreach (rows[i]) begin
            drive_row(rows[i]);
            got = sample(); exp_v = sb.pop_front(); n_checks++;
            if (got !== exp_v) begin
                n_errors++;
                $display("FAIL reset row %0d: got st=%b f=%b ret=%0d, expected st=%b f=%b ret=%0d",
                         i, got[30:26], got[25:16], got[15:0], exp_v[30:26], exp_v[25:16], exp_v[15:0]);
            end
        end
        rows.delete();
    endtask

    task automatic test_lda();
        logic [30:0] got, exp_v;
        add(0,1,0,0,0,5, SF, MI, 0);
        add(0,0,0,0,0,5, SD, PE, 0);
        add(0,0,1,0,0,5, SE, MD, 0);
        add(0,0,0,0,0,5, SW, AL|AC, 0);
        add(0,0,0,0,0,5, SF, MI, 1);
        foreach (rows[i]) begin
            drive_row(rows[i]);
            got = sample(); exp_v = sb.pop_front(); n_checks++;
            if (got !== exp_v) begin
                n_errors++;
                $display("FAIL lda row %0d: got st=%b f=%b ret=%0d, expected st=%b f=%b ret=%0d",
                         i, got[30:26], got[25:16], got[15:0], exp_v[30:26], exp_v[25:16], exp_v[15:0]);
            end
        end
        rows.delete();
    endtask

    task automatic test_sto_wait();
        logic [30:0] got, exp_v;
        add(0,1,0,0,0,6, SF, MI, 1);
        add(0,0,0,0,0,9, SD, PE, 1);
        add(0,0,0,0,0,2, SE, MD|MW, 1);
        add(0,1,0,0,0,2, SE, MD|MW, 1);
        add(0,0,0,0,1,2, SE, MD|MW, 1);
        add(0,0,1,0,0,2, SE, MD|MW, 1);
        add(0,0,0,0,0,2, SW, NO, 1);
        add(0,0,0,0,0,2, SF, MI, 2);
        foreach (rows[i]) begin
            drive_row(rows[i]);
            got = sample(); exp_v = sb.pop_front(); n_checks++;
            if (got !== exp_v) begin
                n_errors++;
                $display("FAIL sto_wait row %0d: got st=%b f=%b ret=%0d, expected st=%b f=%b ret=%0d",
                         i, got[30:26], got[25:16], got[15:0], exp_v[30:26], exp_v[25:16], exp_v[15:0]);
            end
        end
        rows.delete();
    endtask

    task automatic test_skz_jmp();
        logic [30:0] got, exp_v;
        add(0,1,0,0,0,1, SF, MI, 2);
        add(0,0,0,1,0,1, SD, PE, 2);
        add(0,0,1,1,0,1, SE, PE, 2);
        add(0,0,0,1,0,1, SW, NO, 2);
        add(0,1,0,0,0,1, SF, MI, 3);
        add(0,0,0,0,0,1, SD, PE, 3);
        add(0,0,0,0,0,1, SE, NO, 3);
        add(0,0,0,0,0,1, SW, NO, 3);
        add(0,1,0,0,0,7, SF, MI, 4);
        add(0,0,0,0,0,7, SD, PE, 4);
        add(0,0,0,0,0,7, SE, PL, 4);
        add(0,0,0,0,0,7, SW, NO, 4);
        add(0,0,0,0,0,7, SF, MI, 5);
        foreach (rows[i]) begin
            drive_row(rows[i]);
            got = sample(); exp_v = sb.pop_front(); n_checks++;
            if (got !== exp_v) begin
                n_errors++;
                $display("FAIL skz_jmp row %0d: got st=%b f=%b ret=%0d, expected st=%b f=%b ret=%0d",
                         i, got[30:26], got[25:16], got[15:0], exp_v[30:26], exp_v[25:16], exp_v[15:0]);
            end
        end
        rows.delete();
    endtask

    task automatic test_back_to_back();
        logic [30:0] got, exp_v;
        add(0,1,0,0,0,2, SF, MI, 5);
        add(0,0,0,0,0,2, SD, PE, 5);
        add(0,0,1,0,0,2, SE, MD, 5);
        add(0,1,0,0,0,4, SW, AL, 5);
        add(0,1,0,0,0,4, SF, MI, 6);
        add(0,0,0,0,0,4, SD, PE, 6);
        add(0,0,1,0,0,4, SE, MD, 6);
        add(0,0,0,0,0,4, SW, AL, 6);
        add(0,0,0,0,0,4, SF, MI, 7);
        foreach (rows[i]) begin
            drive_row(rows[i]);
            got = sample(); exp_v = sb.pop_front(); n_checks++;
            if (got !== exp_v) begin
                n_errors++;
                $display("FAIL back_to_back row %0d: got st=%b f=%b ret=%0d, expected st=%b f=%b ret=%0d",
                         i, got[30:26], got[25:16], got[15:0], exp_v[30:26], exp_v[25:16], exp_v[15:0]);
            end
        end
        rows.delete();
    endtask

    task automatic test_halt_resume();
        logic [30:0] got, exp_v;
        add(0,1,0,0,0,0, SF, MI, 7);
        add(0,0,0,0,0,0, SD, PE, 7);
        add(0,1,0,0,0,0, SH, HL, 7);
        add(0,0,0,0,1,0, SH, HL, 7);
        add(0,0,0,0,0,0, SF, MI, 7);
        foreach (rows[i]) begin
            drive_row(rows[i]);
            got = sample(); exp_v = sb.pop_front(); n_checks++;
            if (got !== exp_v) begin
                n_errors++;
                $display("FAIL halt_resume row %0d: got st=%b f=%b ret=%0d, expected st=%b f=%b ret=%0d",
                         i, got[30:26], got[25:16], got[15:0], exp_v[30:26], exp_v[25:16], exp_v[15:0]);
            end
        end
        rows.delete();
    endtask

    task automatic test_illegal();
        logic [30:0] got, exp_v;
        add(0,1,0,0,0,9, SF, MI, 7);
        add(0,0,0,0,0,9, SD, PE, 7);
        add(0,0,0,0,1,9, SH, HL|IL, 7);
        add(0,0,0,0,1,9, SH, HL|IL, 7);
        add(1,0,0,0,0,9, SH, HL|IL, 7);
        add(0,0,0,0,0,9, SF, MI, 0);
        foreach (rows[i]) begin
            drive_row(rows[i]);
            got = sample(); exp_v = sb.pop_front(); n_checks++;
            if (got !== exp_v) begin
                n_errors++;
                $display("FAIL illegal row %0d: got st=%b f=%b ret=%0d, expected st=%b f=%b ret=%0d",
                         i, got[30:26], got[25:16], got[15:0], exp_v[30:26], exp_v[25:16], exp_v[15:0]);
            end
        end
        rows.delete();
    endtask

    task automatic test_fetch_timeout();
        logic [30:0] got, exp_v;
        add(1,0,0,0,0,0, SF, NO, 0);
        for (int k = 0; k < 4; k++) add(0,0,0,0,0,0, SF, MI, 0);
        add(0,0,0,0,1,0, SH, HL|BE, 0);
        add(0,0,0,0,1,0, SH, HL|BE, 0);
        add(1,0,0,0,0,0, SH, HL|BE, 0);
        add(0,0,0,0,0,0, SF, MI, 0);
        foreach (rows[i]) begin
            drive_row(rows[i]);
            got = sample(); exp_v = sb.pop_front(); n_checks++;
            if (got !== exp_v) begin
                n_errors++;
                $display("FAIL fetch_timeout row %0d: got st=%b f=%b ret=%0d, expected st=%b f=%b ret=%0d",
                         i, got[30:26], got[25:16], got[15:0], exp_v[30:26], exp_v[25:16], exp_v[15:0]);
            end
        end
        rows.delete();
    endtask

    task automatic test_exec_timeout();
        logic [30:0] got, exp_v;
        add(0,1,0,0,0,3, SF, MI, 0);
        add(0,0,0,0,0,3, SD, PE, 0);
        for (int k = 0; k < 4; k++) add(0,0,0,0,0,3, SE, MD, 0);
        add(0,0,0,0,0,3, SH, HL|BE, 0);
        add(1,0,0,0,0,3, SH, HL|BE, 0);
        add(0,0,0,0,0,3, SF, MI, 0);
        foreach (rows[i]) begin
            drive_row(rows[i]);
            got = sample(); exp_v = sb.pop_front(); n_checks++;
            if (got !== exp_v) begin
                n_errors++;
                $display("FAIL exec_timeout row %0d: got st=%b f=%b ret=%0d, expected st=%b f=%b ret=%0d",
                         i, got[30:26], got[25:16], got[15:0], exp_v[30:26], exp_v[25:16], exp_v[15:0]);
            end
        end
        rows.delete();
    endtask

    task automatic test_rst_mid();
        logic [30:0] got, exp_v;
        add(0,1,0,0,0,5, SF, MI, 0);
        add(0,0,0,0,0,5, SD, PE, 0);
        add(0,0,1,0,0,5, SE, MD, 0);
        add(0,0,0,0,0,5, SW, AL|AC, 0);
        add(0,1,0,0,0,6, SF, MI, 1);
        add(0,0,0,0,0,6, SD, PE, 1);
        add(0,0,0,0,0,6, SE, MD|MW, 1);
        add(1,0,1,0,0,6, SE, NO, 1);
        add(0,0,0,0,0,6, SF, MI, 0);
        foreach (rows[i]) begin
            drive_row(rows[i]);
            got = sample(); exp_v = sb.pop_front(); n_checks++;
            if (got !== exp_v) begin
                n_errors++;
                $display("FAIL rst_mid row %0d: got st=%b f=%b ret=%0d, expected st=%b f=%b ret=%0d",
                         i, got[30:26], got[25:16], got[15:0], exp_v[30:26], exp_v[25:16], exp_v[15:0]);
            end
        end
        rows.delete();
    endtask

    initial begin
        rst           = 1'b1;
        bus.ins_ready = 1'b0;
        bus.da_ready  = 1'b0;
        bus.is_zero   = 1'b0;
        bus.resume    = 1'b0;
        bus.opcode    = '0;

        test_reset();
        test_lda();
        test_sto_wait();
        test_skz_jmp();
        test_back_to_back();
        test_halt_resume();
        test_illegal();
        test_fetch_timeout();
        test_exec_timeout();
        test_rst_mid();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/cpu_ctrl_seq.md
CPU_CTRL_SEQ -- requirements
Module: cpu_ctrl_seq

Interface
REQ-001 Parameter OP_W, default 3: opcode width; legal range 3..8.
REQ-002 Parameter WAIT_MAX, default 15: maximum cycles a memory-wait state is held; legal range 1..255.
REQ-003 Parameter RET_W, default 16: width of the retired-instruction counter.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  synchronous reset, active-high.
REQ-006 opcode  in  OP_W  instruction opcode; valid only while ins_ready=1 in FETCH.
REQ-007 ins_ready  in  1  instruction memory has data.
REQ-008 da_ready  in  1  data memory access is complete.
REQ-009 is_zero  in  1  accumulator-zero flag; sampled in EXEC.
REQ-010 resume  in  1  leaves HALTED when there is no error.
REQ-011 pc_en, pc_load  out  1 each  PC increment and PC load strobes.
REQ-012 mem_ins_en, mem_da_en, mem_da_we  out  1 each  memory strobes.
REQ-013 acc_load, acc_ctrl  out  1 each  accumulator load; source select (0 = ALU, 1 = memory).
REQ-014 halt, illegal_op, bus_err  out  1 each  status flags.
REQ-015 state  out  5  one-hot state: bit0 FETCH, bit1 DECODE, bit2 EXEC, bit3 WB, bit4 HALTED.
REQ-016 retired  out  RET_W  count of retired instructions.

Function
REQ-017 Opcode map: 0 HLT, 1 SKZ, 2 ADD, 3 AND, 4 XOR, 5 LDA, 6 STO, 7 JMP. Any value of 8 or more (possible only when OP_W>3) SHALL be illegal.
REQ-018 The opcode SHALL be captured into an internal IR on the FETCH->DECODE edge. All later decoding uses IR only; opcode changes after capture have no effect.
REQ-019 Outputs SHALL be Moore functions of state, IR and is_zero only. There is no combinational path from ins_ready, da_ready or resume to any output.
REQ-020 FETCH:
- mem_ins_en=1.
- ins_ready=1 -> DECODE.
- Otherwise stay in FETCH, subject to the timeout in REQ-025.
REQ-021 DECODE:
- pc_en=1 for exactly this one cycle.
- HLT -> HALTED.
- Illegal opcode -> HALTED with illegal_op set.
- Otherwise -> EXEC.
REQ-022 EXEC:
- ADD/AND/XOR/LDA/STO: mem_da_en=1; mem_da_we=1 only for STO. Hold until da_ready=1, then -> WB. Timeout per REQ-025 applies.
- JMP: pc_load=1 for one cycle, then -> WB.
- SKZ: pc_en=is_zero for one cycle (skips the next instruction), then -> WB.
REQ-023 WB:
- acc_load=1 for ADD/AND/XOR/LDA.
- acc_ctrl=1 only for LDA.
- retired increments by 1, wrapping at 2^RET_W.
- Next state FETCH.
REQ-024 HALTED:
- halt=1; all strobes are 0.
- resume=1 with illegal_op=0 and bus_err=0 -> FETCH; halt drops in FETCH.
- With an error flag set, only rst exits HALTED.
REQ-025 Wait timeout:
- A wait counter SHALL clear on entry to FETCH or EXEC.
- Each cycle in that state without the relevant ready, the counter increments.
- Ready in any of the first WAIT_MAX cycles is accepted.
- If ready is absent in cycle WAIT_MAX, the next state is HALTED with bus_err set.
REQ-026 resume outside HALTED SHALL be ignored.
REQ-027 If ins_ready/da_ready is asserted in a state that does not wait on it, it SHALL be ignored.
REQ-028 illegal_op and bus_err are sticky and SHALL clear only on rst.
REQ-029 Outputs not named active for a state SHALL be 0 in that state.
REQ-030 Unreachable state encodings SHALL recover to FETCH on the next edge with all strobes 0.

Reset
REQ-031 rst=1 at a clock edge SHALL set:
- state=FETCH (00001), IR=0, wait counter=0, retired=0;
- illegal_op=0, bus_err=0, halt=0.
REQ-032 While rst=1, all strobes SHALL be driven 0 regardless of state.
REQ-033 rst asserted mid-instruction, including during a wait or HALTED, SHALL abandon the instruction. No acc_load and no retired increment occur for it.

Verification
REQ-034 LDA (5) with ins_ready and da_ready immediate -> states FETCH,DECODE,EXEC,WB; pc_en once in DECODE; acc_load=1 and acc_ctrl=1 in WB; retired=1; 4 cycles.
REQ-035 STO (6) with da_ready delayed 3 cycles -> mem_da_en=1 and mem_da_we=1 for 4 EXEC cycles; no acc_load; retired+1.
REQ-036 SKZ with is_zero=1 -> pc_en pulses in DECODE and EXEC (2 total). SKZ with is_zero=0 -> 1 pulse. JMP -> pc_load exactly one cycle in EXEC.
REQ-037 HLT -> HALTED, halt=1. resume=1 -> FETCH next cycle. resume while in EXEC -> ignored.
REQ-038 WAIT_MAX=4 with ins_ready held 0 -> 4 FETCH cycles, then HALTED with bus_err=1; resume has no effect; rst clears.
REQ-039 OP_W=4, opcode 9 -> HALTED with illegal_op=1 after DECODE; retired unchanged. rst in the EXEC wait -> state 00001, retired 0.
